instr_fetch_unit: RTL and testbench

//  Parametrised fetch front-end replacing the bare PC -> instruction-memory path of the core top.
//  - Owns the fetch PC.
//  - Issues requests to instruction memory over a valid/ready handshake.
//  - Buffers returned instructions, with their PCs, in a prefetch FIFO.
//  - Hands instructions to the decoder over valid/ready.
//  - Branch/jump redirect flushes the buffer and discards any in-flight response.

---
 rtl/instr_fetch_unit_pkg.sv | 19 +
 rtl/instr_fetch_unit_fetch_fifo.sv | 60 ++++++
 rtl/instr_fetch_unit.sv | 126 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared types and constants for the instruction fetch front-end
package instr_fetch_unit_pkg;

  // Fetch sequencer states: issue a request, wait for its answer, or swallow a stale answer
  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    WAIT_RESP = 2'd1,
    DRAIN     = 2'd2
  } fetch_state_t;

  localparam int INSTR_BYTES = 4;
  localparam int INSTR_WIDTH = 32;

  // Byte address of the instruction that follows pc, wrapping at the top of the address space
  function automatic logic [63:0] next_pc64(input logic [63:0] pc);
    return pc + 64'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// rtl/instr_fetch_unit_fetch_fifo.sv - synchronous prefetch FIFO with flush and occupancy count
module fetch_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 96,
  parameter int DEPTH_POW  = 2
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [DEPTH_POW:0]    level,
  output logic                  empty,
  output logic                  full
);

  localparam int DEPTH = 1 << DEPTH_POW;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH_POW-1:0]  r_wr_ptr;
  logic [DEPTH_POW-1:0]  r_rd_ptr;
  logic [DEPTH_POW:0]    r_level;
  logic                  w_push;
  logic                  w_pop;

  // Guard against writes into a full FIFO or reads from an empty one
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  assign empty    = (r_level == '0);
  assign full     = (r_level == (DEPTH_POW + 1)'(DEPTH));
  assign level    = r_level;
  assign pop_data = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the queue in one edge
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= r_level + (DEPTH_POW + 1)'(w_push) - (DEPTH_POW + 1)'(w_pop);
    end
  end

  // Entry storage; contents need no reset because occupancy gates every read
  always_ff @(posedge clk_in) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch PC, single-outstanding imem requests, prefetch FIFO; IFU_BYPASS_EN adds zero-latency bypass
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                              ADDR_WIDTH_POW = 6,
  parameter int                              FIFO_DEPTH_POW = 2,
  parameter logic [(1<<ADDR_WIDTH_POW)-1:0]  RESET_PC       = '0
) (
  input  logic                             clk_in,
  input  logic                             reset,
  output logic                             imem_req_valid_out,
  input  logic                             imem_req_ready_in,
  output logic [(1<<ADDR_WIDTH_POW)-1:0]   imem_addr_out,
  input  logic                             imem_resp_valid_in,
  input  logic [INSTR_WIDTH-1:0]           imem_resp_data_in,
  input  logic                             redirect_valid_in,
  input  logic [(1<<ADDR_WIDTH_POW)-1:0]   redirect_pc_in,
  output logic                             instr_valid_out,
  input  logic                             instr_ready_in,
  output logic [INSTR_WIDTH-1:0]           instr_out,
  output logic [(1<<ADDR_WIDTH_POW)-1:0]   instr_pc_out,
  output logic [FIFO_DEPTH_POW:0]          fifo_level_out
);

  localparam int AW      = 1 << ADDR_WIDTH_POW;
  localparam int ENTRY_W = INSTR_WIDTH + AW;

  fetch_state_t          r_state;
  fetch_state_t          w_next_state;
  logic [AW-1:0]         r_fetch_pc;
  logic [AW-1:0]         r_req_pc;

  logic                  w_req_valid;
  logic                  w_req_accept;
  logic                  w_resp_live;
  logic                  w_bypass;
  logic                  w_push;
  logic                  w_pop;
  logic [AW-1:0]         w_redirect_pc;
  logic [ENTRY_W-1:0]    w_fifo_wr_data;
  logic [ENTRY_W-1:0]    w_fifo_rd_data;
  logic [FIFO_DEPTH_POW:0] w_fifo_level;
  logic                  w_fifo_empty;
  logic                  w_fifo_full;

  // Instructions are word aligned, so the low two redirect bits are cleared
  assign w_redirect_pc = redirect_pc_in & ~AW'(INSTR_BYTES - 1);

  // Only issue while reset is released and the response is guaranteed a FIFO slot
  assign w_req_valid  = (r_state == FETCH) & ~w_fifo_full & reset;
  assign w_req_accept = w_req_valid & imem_req_ready_in;

  // A response is only meaningful while waiting for it; in DRAIN it is stale
  assign w_resp_live = (r_state == WAIT_RESP) & imem_resp_valid_in;

`ifdef IFU_BYPASS_EN
  assign w_bypass = w_fifo_empty & w_resp_live & instr_ready_in & ~redirect_valid_in;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push         = w_resp_live & ~redirect_valid_in & ~w_bypass;
  assign w_pop          = ~w_fifo_empty & instr_ready_in & ~redirect_valid_in;
  assign w_fifo_wr_data = {imem_resp_data_in, r_req_pc};

  fetch_fifo #(
    .DATA_WIDTH (ENTRY_W),
    .DEPTH_POW  (FIFO_DEPTH_POW)
  ) u_fetch_fifo (
    .clk_in    (clk_in),
    .reset     (reset),
    .push      (w_push),
    .pop       (w_pop),
    .flush     (redirect_valid_in),
    .push_data (w_fifo_wr_data),
    .pop_data  (w_fifo_rd_data),
    .level     (w_fifo_level),
    .empty     (w_fifo_empty),
    .full      (w_fifo_full)
  );

  // State register
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) r_state <= FETCH;
    else        r_state <= w_next_state;
  end

  // Next-state logic; a redirect overrides the normal flow and decides whether a stale answer is pending
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FETCH:     if (w_req_accept)       w_next_state = WAIT_RESP;
      WAIT_RESP: if (imem_resp_valid_in) w_next_state = FETCH;
      DRAIN:     if (imem_resp_valid_in) w_next_state = FETCH;
      default:                           w_next_state = FETCH;
    endcase
    if (redirect_valid_in) begin
      if (w_req_accept ||
          ((r_state == WAIT_RESP || r_state == DRAIN) && !imem_resp_valid_in))
        w_next_state = DRAIN;
      else
        w_next_state = FETCH;
    end
  end

  // Fetch PC: redirect wins, otherwise advance once the current request is answered
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset)                 r_fetch_pc <= RESET_PC;
    else if (redirect_valid_in) r_fetch_pc <= w_redirect_pc;
    else if (w_resp_live)       r_fetch_pc <= r_fetch_pc + AW'(INSTR_BYTES);
  end

  // Remember which PC the outstanding request belongs to, so the response is tagged correctly
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset)            r_req_pc <= RESET_PC;
    else if (w_req_accept) r_req_pc <= r_fetch_pc;
  end

  assign imem_req_valid_out = w_req_valid;
  assign imem_addr_out      = r_fetch_pc;
  assign instr_valid_out    = (~w_fifo_empty | w_bypass) & ~redirect_valid_in;
  assign instr_out          = w_bypass ? imem_resp_data_in : w_fifo_rd_data[AW +: INSTR_WIDTH];
  assign instr_pc_out       = w_bypass ? r_req_pc : w_fifo_rd_data[AW-1:0];
  assign fifo_level_out     = w_fifo_level;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed and randomized self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic [2:0]  level;

  always #5 clk_in = ~clk_in;

`ifdef IFU_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  instr_fetch_unit dut (
    .clk_in             (clk_in),
    .reset              (reset),
    .imem_req_valid_out (req_valid),
    .imem_req_ready_in  (req_ready),
    .imem_addr_out      (req_addr),
    .imem_resp_valid_in (resp_valid),
    .imem_resp_data_in  (resp_data),
    .redirect_valid_in  (redirect_valid),
    .redirect_pc_in     (redirect_pc),
    .instr_valid_out    (instr_valid),
    .instr_ready_in     (instr_ready),
    .instr_out          (instr),
    .instr_pc_out       (instr_pc),
    .fifo_level_out     (level)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state: the decoder must see consecutive words starting at the last restart point
  logic [63:0] exp_pc;
  bit          mem_busy, mem_stale;
  int          mem_wait;
  logic [63:0] mem_addr;
  int          lat;
  bit          hold_pending;
  logic [63:0] hold_addr;
  bit          lat_pending, lat_byp;
  int          lat_checks;
  int          n_req;
  logic [63:0] last_req_addr;
  longint      req_log_addr[$];
  longint      req_log_cyc[$];
  longint      del_log_pc[$];
  longint      del_log_cyc[$];

  function automatic logic [31:0] instr_of(input logic [63:0] pc);
    return (pc[31:0] * 32'h9E3779B1) ^ pc[63:32] ^ 32'h0000_5A5A;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs already set at the falling edge; evaluate, check, then advance
  task automatic cycle();
    resp_valid = mem_busy && (mem_wait == 0);
    resp_data  = resp_valid ? instr_of(mem_addr) : $urandom;
    #1;
    chk("level_bound", 64'(level <= 3'd4), 64'd1);
    if (level == 3'd4) chk("no_req_when_full", 64'(req_valid), 64'd0);
    if (redirect_valid) chk("valid_masked_on_redirect", 64'(instr_valid), 64'd0);
    if (hold_pending) begin
      chk("req_hold_valid", 64'(req_valid), 64'd1);
      chk("req_hold_addr", req_addr, hold_addr);
    end
    if (lat_pending) begin
      lat_checks++;
      if (lat_byp) chk("bypass_level_stays_0", 64'(level), 64'd0);
      else begin
        chk("push_level_1", 64'(level), 64'd1);
        if (!redirect_valid) chk("resp_to_valid_next_cycle", 64'(instr_valid), 64'd1);
      end
    end
    lat_pending = 1'b0;
    if (resp_valid && !mem_stale && !redirect_valid && level == 3'd0) begin
      if (instr_ready) chk("bypass_same_cycle_valid", 64'(instr_valid), 64'(BYP));
      lat_pending = 1'b1;
      lat_byp     = instr_ready && BYP;
    end
    if (instr_valid && instr_ready) begin
      chk("deliver_pc", instr_pc, exp_pc);
      chk("deliver_data", 64'(instr), 64'(instr_of(exp_pc)));
      del_log_pc.push_back(longint'(instr_pc));
      del_log_cyc.push_back(longint'(cyc));
      exp_pc = exp_pc + 64'd4;
    end
    if (redirect_valid) exp_pc = {redirect_pc[63:2], 2'b00};
    if (resp_valid) mem_busy = 1'b0;
    else if (mem_busy) mem_wait--;
    if (redirect_valid && mem_busy) mem_stale = 1'b1;
    if (req_valid && req_ready) begin
      chk("single_outstanding", 64'(mem_busy), 64'd0);
      mem_busy  = 1'b1;
      mem_addr  = req_addr;
      mem_wait  = lat;
      mem_stale = redirect_valid;
      last_req_addr = req_addr;
      n_req++;
      req_log_addr.push_back(longint'(req_addr));
      req_log_cyc.push_back(longint'(cyc));
    end
    hold_pending = req_valid && !req_ready && !redirect_valid;
    hold_addr    = req_addr;
    @(posedge clk_in);
    cyc++;
    @(negedge clk_in);
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    resp_valid     = 1'b0;
    redirect_valid = 1'b0;
    #1;
    chk("rst_req_valid", 64'(req_valid), 64'd0);
    chk("rst_addr", req_addr, 64'd0);
    chk("rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    mem_busy = 0; mem_stale = 0; mem_wait = 0;
    hold_pending = 0; lat_pending = 0;
    exp_pc = 64'd0;
    @(posedge clk_in);
    @(negedge clk_in);
    reset = 1'b1;
  endtask

  task automatic wait_req(input string tag);
    int n0 = n_req;
    for (int i = 0; i < 40 && n_req == n0; i++) cycle();
    if (n_req == n0) chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_delivery(input string tag);
    int n0 = del_log_pc.size();
    for (int i = 0; i < 40 && del_log_pc.size() == n0; i++) cycle();
    if (del_log_pc.size() == n0) chk({tag, "_timeout"}, 64'd0, 64'd1);
    else chk(tag, 64'(del_log_pc[n0]), 64'(exp_pc - 64'd4));
  endtask

  initial begin
    int start, d0, r0;
    reset = 1'b0; req_ready = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; resp_valid = 1'b0; resp_data = '0;
    lat = 0; n_req = 0; lat_checks = 0; last_req_addr = '0;
    @(negedge clk_in);

    // 1: zero-wait memory, decoder always ready
    req_ready = 1'b1; instr_ready = 1'b1; lat = 0;
    do_reset();
    start = cyc;
    req_log_addr.delete(); req_log_cyc.delete(); del_log_pc.delete(); del_log_cyc.delete();
    for (int i = 0; i < 8; i++) cycle();
    if (req_log_addr.size() >= 3 && del_log_pc.size() >= 3) begin
      chk("t1_first_req_cycle", 64'(req_log_cyc[0]), 64'(start));
      chk("t1_req0", 64'(req_log_addr[0]), 64'h0);
      chk("t1_req1", 64'(req_log_addr[1]), 64'h4);
      chk("t1_req2", 64'(req_log_addr[2]), 64'h8);
      chk("t1_pc0", 64'(del_log_pc[0]), 64'h0);
      chk("t1_pc1", 64'(del_log_pc[1]), 64'h4);
      chk("t1_pc2", 64'(del_log_pc[2]), 64'h8);
      chk("t1_first_latency", 64'(del_log_cyc[0] - req_log_cyc[0]), BYP ? 64'd1 : 64'd2);
      chk("t1_spacing01", 64'(del_log_cyc[1] - del_log_cyc[0]), 64'd2);
      chk("t1_spacing12", 64'(del_log_cyc[2] - del_log_cyc[1]), 64'd2);
    end else chk("t1_activity", 64'd0, 64'd1);

    // 2: decoder stalls for 20 cycles
    instr_ready = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
    chk("t2_level_full", 64'(level), 64'd4);
    chk("t2_req_idle_when_full", 64'(req_valid), 64'd0);
    d0 = del_log_pc.size();
    instr_ready = 1'b1;
    for (int i = 0; i < 20; i++) cycle();
    chk("t2_drained_at_least_4", 64'(del_log_pc.size() >= d0 + 4), 64'd1);

    // 3: redirect while waiting, stale response three cycles later
    lat = 3;
    wait_req("t3_accept");
    lat = 0;
    redirect_valid = 1'b1; redirect_pc = 64'h100;
    cycle();
    redirect_valid = 1'b0;
    wait_req("t3_new_req");
    chk("t3_req_addr", last_req_addr, 64'h100);
    wait_delivery("t3_first_pc");
    chk("t3_first_pc_abs", 64'(del_log_pc[del_log_pc.size()-1]), 64'h100);

    // 4: unaligned redirect with a partly filled FIFO
    instr_ready = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    redirect_valid = 1'b1; redirect_pc = 64'h203;
    cycle();
    redirect_valid = 1'b0;
    chk("t4_level_cleared", 64'(level), 64'd0);
    wait_req("t4_new_req");
    chk("t4_req_addr", last_req_addr, 64'h200);
    instr_ready = 1'b1;
    wait_delivery("t4_first_pc");

    // 5: address wrap at the top of the space
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    wait_req("t5_top_req");
    chk("t5_top_addr", last_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    wait_req("t5_wrap_req");
    chk("t5_wrap_addr", last_req_addr, 64'h0);
    for (int i = 0; i < 6; i++) cycle();

    // 6 and soak: random handshakes, latencies and redirects, with a mid-run reset
    r0 = lat_checks;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        instr_ready = 1'b0;
        do_reset();
      end
      instr_ready    = ($urandom_range(0, 3) != 0);
      req_ready      = ($urandom_range(0, 2) != 0);
      lat            = $urandom_range(0, 3);
      redirect_valid = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      else                           redirect_pc = {$urandom, $urandom};
      cycle();
    end
    redirect_valid = 1'b0;
    chk("t6_latency_cases_seen", 64'(lat_checks > r0), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
